decode_flow_ctrl: RTL

DECODE_FLOW_CTRL -- requirements
Module: decode_flow_ctrl

---
 rtl/InsnDecodePkg.sv | 21 ++
 rtl/core.sv | 10 +
 rtl/decode_flow_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/InsnDecodePkg.sv
// Light pre-decode helpers usable at fetch time, before full decode.
// Latency: combinational functions.
// Backpressure: n/a.
package InsnDecodePkg;

   // Control-transfer encodings: conditional branches, JAL and JALR.
   // Masks cover the full word so callers can hand in the raw instruction.
   localparam logic [core::INSN_WIDTH-1:0] BRANCH_MASK  = 'h0000_007F;
   localparam logic [core::INSN_WIDTH-1:0] BRANCH_MATCH = 'h0000_0063;
   localparam logic [core::INSN_WIDTH-1:0] JAL_MASK     = 'h0000_007F;
   localparam logic [core::INSN_WIDTH-1:0] JAL_MATCH    = 'h0000_006F;
   localparam logic [core::INSN_WIDTH-1:0] JALR_MASK    = 'h0000_707F;
   localparam logic [core::INSN_WIDTH-1:0] JALR_MATCH   = 'h0000_0067;

   function automatic logic insn_is_branch(input logic [core::INSN_WIDTH-1:0] insn);
      return ((insn & BRANCH_MASK) == BRANCH_MATCH) ||
             ((insn & JAL_MASK)    == JAL_MATCH)    ||
             ((insn & JALR_MASK)   == JALR_MATCH);
   endfunction

endpackage

// File: rtl/core.sv
// Core-wide sizing shared by the front-end blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package core;

   localparam int ADDR_WIDTH      = 32;
   localparam int INSN_ADDR_START = 2;
   localparam int INSN_WIDTH      = 32;

endpackage

// File: rtl/decode_flow_ctrl.sv
// Fetch->Decode skid queue (2 entries) that stalls issue behind an unresolved branch and flushes on a taken one.
// Latency: a beat pushed into an empty queue is offered to Decode the next cycle; redirect pulses the cycle after a taken resolve.
// Backpressure: fetch_ready drops when the queue is full, in FLUSH or in reset; dec_valid is held off while a branch is outstanding.
module decode_flow_ctrl #(
   parameter int ADDR_WIDTH      = core::ADDR_WIDTH,
   parameter int INSN_ADDR_START = core::INSN_ADDR_START,
   parameter int INSN_WIDTH      = core::INSN_WIDTH
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  fetch_valid,
   input  logic [ADDR_WIDTH-INSN_ADDR_START-1:0] fetch_addr,
   input  logic [INSN_WIDTH-1:0]                 fetch_insn,
   output logic                                  fetch_ready,
   output logic                                  dec_valid,
   output logic [ADDR_WIDTH-INSN_ADDR_START-1:0] dec_addr,
   output logic [INSN_WIDTH-1:0]                 dec_insn,
   input  logic                                  dec_ready,
   input  logic                                  br_resolve,
   input  logic                                  br_taken,
   input  logic [ADDR_WIDTH-INSN_ADDR_START-1:0] br_target,
   output logic                                  redirect_valid,
   output logic [ADDR_WIDTH-INSN_ADDR_START-1:0] redirect_addr,
   output logic [15:0]                           stall_cnt
);

   localparam int AW = ADDR_WIDTH - INSN_ADDR_START;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] BR_WAIT = 2'd1;
   localparam logic [1:0] FLUSH   = 2'd2;

   logic [1:0]            state;
   logic [1:0]            count;
   logic                  rd_ptr;
   logic                  wr_ptr;
   logic [AW-1:0]         addr_mem [2];
   logic [INSN_WIDTH-1:0] insn_mem [2];
   logic                  br_mem   [2];
   logic                  redirect_q;

   logic push;
   logic pop;
   logic head_is_branch;
   logic take_flush;

   // Handshakes. Both ready/valid are forced low in reset without waiting for an edge.
   assign fetch_ready    = rst && (count < 2'd2) && (state != FLUSH);
   assign dec_valid      = rst && (count != 2'd0) && (state == IDLE);
   assign push           = fetch_valid && fetch_ready;
   assign pop            = dec_valid && dec_ready;
   assign head_is_branch = br_mem[rd_ptr];
   // A taken resolve only counts while a branch is actually outstanding.
   assign take_flush     = (state == BR_WAIT) && br_resolve && br_taken;

   assign dec_addr = addr_mem[rd_ptr];
   assign dec_insn = insn_mem[rd_ptr];

   // Mask the registered pulse if reset lands in the FLUSH cycle, so an abandoned flush never redirects.
   assign redirect_valid = redirect_q && rst;

   // Queue storage: written on an accepted push; a push racing a taken flush is discarded.
   always_ff @(posedge clk) begin
      if (push && !take_flush) begin
         addr_mem[wr_ptr] <= fetch_addr;
         insn_mem[wr_ptr] <= fetch_insn;
         br_mem[wr_ptr]   <= InsnDecodePkg::insn_is_branch(fetch_insn);
      end
   end

   // Queue pointers and occupancy; a taken flush empties the queue at the same edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else if (take_flush) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         if (push && !pop) begin
            count <= count + 2'd1;
         end else if (!push && pop) begin
            count <= count - 2'd1;
         end
      end
   end

   // Issue control: stop after issuing a branch, resume on resolve, spend one cycle flushing on a taken one.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (pop && head_is_branch) begin
                  state <= BR_WAIT;
               end
            end
            BR_WAIT: begin
               if (br_resolve) begin
                  state <= br_taken ? FLUSH : IDLE;
               end
            end
            FLUSH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Redirect to Fetch: one-cycle pulse after a taken resolve; the address is held between pulses.
   always_ff @(posedge clk) begin
      if (!rst) begin
         redirect_q    <= 1'b0;
         redirect_addr <= '0;
      end else begin
         redirect_q <= take_flush;
         if (take_flush) begin
            redirect_addr <= br_target;
         end
      end
   end

   // Branch-wait cycle counter, saturating rather than wrapping.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= 16'd0;
      end else if ((state == BR_WAIT) && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule
